// File: rtl/cpu_pkg.sv
// Shared constants, opcode and FSM state encodings for the execute stage.
// The S_MUL state exists only when EXEC_MUL_EN is defined.
package cpu_pkg;

  localparam int CPU_DATA_W  = 16;
  localparam int CPU_ADDR_W  = 4;
  localparam int CPU_MUL_CYC = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_LDI = 4'd7,
    OP_MUL = 4'd8,
    OP_NOP = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef EXEC_MUL_EN
    S_MUL  = 2'd3,
`endif
    S_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one partial product per cycle, low-half result.
// done_o/p_o are valid in the cycle of the final iteration.
module seq_multiplier #(
  parameter int W   = 16,
  parameter int CYC = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] p_o
);

  localparam int CW = $clog2(CYC + 1);

  logic [W-1:0]  a_q, b_q, acc_q, acc_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  assign acc_d  = acc_q + (b_q[0] ? a_q : '0);
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign p_o    = acc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= CW'(CYC);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      acc_q <= acc_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_writeback_stage.sv
// Execute/write-back stage: 1-cycle ALU, registered RF write pulse, Z/N/C flags.
// Define EXEC_MUL_EN to build the iterative multiplier for opcode 8.
module exec_writeback_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int MUL_CYC = CPU_MUL_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [7:0]        imm,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              illegal
);

  state_e state_q, state_d;

  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [7:0]        imm_q, imm_d;
  logic              wen_q, wen_d;
  logic              ill_q, ill_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d;

  logic [DATA_W-1:0] a, b, alu_res;
  logic [DATA_W:0]   sum, dif;
  logic              alu_c, alu_wr, is_ill;

  assign a   = rf_read_data1;
  assign b   = rf_read_data2;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

`ifdef EXEC_MUL_EN
  logic              is_mul, mul_start, mul_done;
  logic [DATA_W-1:0] mul_p;

  seq_multiplier #(
    .W   (DATA_W),
    .CYC (MUL_CYC)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );
`else
  localparam int unused_mul_cyc = MUL_CYC;
`endif

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_wr  = 1'b1;
    is_ill  = 1'b0;
`ifdef EXEC_MUL_EN
    is_mul  = 1'b0;
`endif
    unique case (op_q)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_SUB: begin
        alu_res = dif[DATA_W-1:0];
        alu_c   = dif[DATA_W];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: alu_res = a << b[3:0];
      OP_SHR: alu_res = a >> b[3:0];
      OP_LDI: alu_res = DATA_W'(imm_q);
      OP_MUL: begin
        alu_wr = 1'b0;
`ifdef EXEC_MUL_EN
        is_mul = 1'b1;
`else
        is_ill = 1'b1;
`endif
      end
      OP_NOP: alu_wr = 1'b0;
      default: begin
        alu_wr = 1'b0;
        is_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    wen_d   = 1'b0;
    ill_d   = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
`ifdef EXEC_MUL_EN
    mul_start = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          rd_d    = rd;
          rs1_d   = rs1;
          rs2_d   = rs2;
          imm_d   = imm;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        ill_d   = is_ill;
        if (alu_wr) begin
          wen_d   = 1'b1;
          wreg_d  = rd_q;
          wdata_d = alu_res;
          z_d     = (alu_res == '0);
          n_d     = alu_res[DATA_W-1];
          c_d     = alu_c;
        end
`ifdef EXEC_MUL_EN
        if (is_mul) begin
          mul_start = 1'b1;
          state_d   = S_MUL;
        end
`endif
      end
`ifdef EXEC_MUL_EN
      S_MUL: begin
        if (mul_done) begin
          state_d = S_WB;
          wen_d   = 1'b1;
          wreg_d  = rd_q;
          wdata_d = mul_p;
          z_d     = (mul_p == '0);
          n_d     = mul_p[DATA_W-1];
          c_d     = 1'b0;
        end
      end
`endif
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      wen_q   <= 1'b0;
      ill_q   <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      wen_q   <= wen_d;
      ill_q   <= ill_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
    end
  end

  assign instr_ready   = (state_q == S_IDLE);
  assign rf_read_reg1  = rs1_q;
  assign rf_read_reg2  = rs2_q;
  assign rf_write_reg  = wreg_q;
  assign rf_write_data = wdata_q;
  assign rf_write_en   = wen_q;
  assign illegal       = ill_q;
  assign flag_z        = z_q;
  assign flag_n        = n_q;
  assign flag_c        = c_q;

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Bench for exec_writeback_stage with a 16x16 register-file model.
// Expected results come from an arithmetic reference model of the ISA.
module tb_exec_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [7:0]  imm;
  logic [3:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [15:0] rf_read_data1, rf_read_data2, rf_write_data;
  logic        rf_write_en;
  logic        flag_z, flag_n, flag_c, illegal;

  logic [15:0] rf [16] = '{default: 16'h0};
  int          exp_rf [16];
  logic [2:0]  exp_fl;
  int          total = 0;
  int          bad = 0;

`ifdef EXEC_MUL_EN
  localparam int MUL_BUSY = 2 + 16;
`endif

  always #5 clk = ~clk;

  assign rf_read_data1 = rf[rf_read_reg1];
  assign rf_read_data2 = rf[rf_read_reg2];

  always @(posedge clk)
    if (rf_write_en) rf[rf_write_reg] <= rf_write_data;

  exec_writeback_stage dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .imm           (imm),
    .rf_read_reg1  (rf_read_reg1),
    .rf_read_reg2  (rf_read_reg2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_write_en   (rf_write_en),
    .flag_z        (flag_z),
    .flag_n        (flag_n),
    .flag_c        (flag_c),
    .illegal       (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int op, input int d, input int s1,
                      input int s2, input int im);
    @(negedge clk);
    instr_valid = 1'b1;
    opcode = 4'(op);
    rd     = 4'(d);
    rs1    = 4'(s1);
    rs2    = 4'(s2);
    imm    = 8'(im);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic exec_instr(input int op, input int d, input int s1,
                            input int s2, input int im);
    longint a, b, r;
    bit     c, wr, il;
    int     busy, k, wens, ills, wk;
    logic [3:0] s1v, s2v;
    a = exp_rf[s1];
    b = exp_rf[s2];
    r = 0; c = 0; wr = 1; il = 0; busy = 2;
    case (op)
      0: begin r = a + b; c = (r > 65535); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * (64'd1 << (b % 16));
      6: r = a / (64'd1 << (b % 16));
      7: r = im;
      8: begin
`ifdef EXEC_MUL_EN
        r = a * b;
        busy = MUL_BUSY;
`else
        wr = 0;
        il = 1;
`endif
      end
      9: wr = 0;
      default: begin wr = 0; il = 1; end
    endcase
    r = ((r % 65536) + 65536) % 65536;
    if (wr) begin
      exp_rf[d] = int'(r);
      exp_fl = {r == 0, r >= 32768, c};
    end
    send(op, d, s1, s2, im);
    wens = 0; ills = 0; wk = -1; k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (instr_ready) break;
      if (rf_write_en) begin wens++; wk = k; end
      if (illegal) ills++;
      k++;
    end
    s1v = 4'(s1);
    s2v = 4'(s2);
    chk("busy_cycles", k, busy);
    chk("wen_count", wens, 32'(wr));
    if (wr) chk("wen_slot", wk, busy - 1);
    chk("illegal_cnt", ills, 32'(il));
    chk("rd_value", rf[d], exp_rf[d]);
    chk("flags", {flag_z, flag_n, flag_c}, exp_fl);
    chk("read_addrs", {rf_read_reg1, rf_read_reg2}, {s1v, s2v});
  endtask

  task automatic reset_during(input int op, input int d, input int s1,
                              input int s2, input int kat,
                              input bit in_wb);
    int old;
    old = exp_rf[d];
    send(op, d, s1, s2, 0);
    repeat (kat + 1) @(negedge clk);
    if (in_wb) chk("pre_rst_wen", rf_write_en, 1);
    reset = 1'b1;
    #1;
    chk("rst_wen", rf_write_en, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_illegal", illegal, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_fl = 3'b000;
    repeat (25) @(negedge clk);
    chk("rst_rd_kept", rf[d], old);
    chk("rst_raddr", {rf_read_reg1, rf_read_reg2}, 0);
    chk("rst_wreg", {rf_write_reg, rf_write_data}, 0);
  endtask

  initial begin
    int kat;
    reset = 1'b1;
    instr_valid = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    foreach (exp_rf[i]) exp_rf[i] = 0;
    exp_fl = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_ready", instr_ready, 1);
    chk("reset_wen", rf_write_en, 0);
    chk("reset_wreg", rf_write_reg, 0);
    chk("reset_wdata", rf_write_data, 0);
    chk("reset_flags", {flag_z, flag_n, flag_c}, 0);
    chk("reset_illegal", illegal, 0);
    reset = 1'b0;

    exec_instr(7, 1, 0, 0, 'h12);
    exec_instr(7, 2, 0, 0, 'h34);
    exec_instr(0, 3, 1, 2, 0);
    chk("t1_r3", rf[3], 16'h0046);
    chk("t1_flags", {flag_z, flag_n, flag_c}, 3'b000);

    exec_instr(7, 2, 0, 0, 1);
    exec_instr(1, 1, 0, 2, 0);
    chk("t2_r1", rf[1], 16'hFFFF);
    exec_instr(0, 4, 1, 2, 0);
    chk("t2_r4", rf[4], 16'h0000);
    chk("t2_add_fl", {flag_z, flag_n, flag_c}, 3'b101);
    exec_instr(1, 5, 2, 1, 0);
    chk("t2_r5", rf[5], 16'h0002);
    chk("t2_sub_fl", {flag_z, flag_n, flag_c}, 3'b001);

    exec_instr(7, 1, 0, 0, 'hF3);
    exec_instr(7, 2, 0, 0, 4);
    exec_instr(5, 6, 1, 2, 0);
    chk("t3_shl", rf[6], 16'h0F30);
    exec_instr(7, 8, 0, 0, 'h80);
    exec_instr(7, 9, 0, 0, 8);
    exec_instr(5, 10, 8, 9, 0);
    chk("t3_r10", rf[10], 16'h8000);
    chk("t3_neg_fl", {flag_z, flag_n, flag_c}, 3'b010);
    exec_instr(7, 11, 0, 0, 15);
    exec_instr(6, 12, 10, 11, 0);
    chk("t3_shr", rf[12], 16'h0001);

    exec_instr(7, 13, 0, 0, 1);
    exec_instr(5, 13, 13, 9, 0);
    chk("t4_r13", rf[13], 16'h0100);
    exec_instr(7, 2, 0, 0, 'h31);
    exec_instr(8, 7, 13, 2, 0);
`ifdef EXEC_MUL_EN
    chk("t4_mul", rf[7], 16'h3100);
`else
    chk("t4_mul_off", rf[7], 16'h0000);
`endif

    exec_instr(0, 14, 10, 10, 0);
    exec_instr(12, 15, 1, 2, 0);
    exec_instr(9, 15, 1, 2, 0);
    chk("t5_flags", {flag_z, flag_n, flag_c}, 3'b101);
    chk("t5_r15", rf[15], 16'h0000);

`ifdef EXEC_MUL_EN
    kat = 5;
`else
    kat = 0;
`endif
    reset_during(8, 7, 13, 2, kat, 1'b0);
    reset_during(0, 14, 1, 2, 1, 1'b1);

    for (int n = 0; n < 80; n++) begin
      exec_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 16; i++) chk("final_rf", rf[i], exp_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
